zad7988_averager: RTL

Downstream stage of the AD7988 acquisition controller. Consumes its 16-bit sample stream (data plus one-cycle valid strobe), boxcar-averages every 2^LOG2_N samples into one decimated result, and buffers the results in a small FIFO with a valid/ready output handshake for the packetizer or UART stage. Overruns are flagged, never stalled, because the ADC controller has no back-pressure input.

---
 rtl/zad7988_pkg.sv | 19 +
 rtl/zad7988_averager_fifo.sv | 73 +++++++
 rtl/zad7988_averager.sv | 105 ++++++++++
 3 files changed

// File: rtl/zad7988_pkg.sv
// zad7988_pkg: shared definitions for the AD7988 averaging stage.
//   ADC_W                 sample width of the AD7988 stream
//   LOG2_N_MIN/MAX        legal range of the averaging exponent
//   LOG2_DEPTH_MIN/MAX    legal range of the result FIFO depth exponent
//   params_legal()        elaboration-time range check used by the top
package zad7988_pkg;

  localparam int ADC_W          = 16;
  localparam int LOG2_N_MIN     = 0;
  localparam int LOG2_N_MAX     = 8;
  localparam int LOG2_DEPTH_MIN = 1;
  localparam int LOG2_DEPTH_MAX = 6;

  function automatic logic params_legal(input int log2_n, input int log2_depth);
    return (log2_n >= LOG2_N_MIN) && (log2_n <= LOG2_N_MAX) &&
           (log2_depth >= LOG2_DEPTH_MIN) && (log2_depth <= LOG2_DEPTH_MAX);
  endfunction

endpackage

// File: rtl/zad7988_averager_fifo.sv
// zsync_fifo: synchronous FIFO with a registered head word.
//   clk, rst    clock, asynchronous active-high reset
//   push, wdata write request and data (ignored when full unless popping)
//   pop         read request (ignored when empty)
//   rdata       registered head of the queue
//   empty, full occupancy flags
//   fill        occupancy 0..2^LOG2_DEPTH
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module zsync_fifo #(
  parameter int WIDTH      = 16,
  parameter int LOG2_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rdata,
  output logic                  empty,
  output logic                  full,
  output logic [LOG2_DEPTH:0]   fill
);

  localparam int DEPTH = 1 << LOG2_DEPTH;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [LOG2_DEPTH:0] wr_ptr;
  logic [LOG2_DEPTH:0] rd_ptr;
  logic [LOG2_DEPTH:0] wr_ptr_nxt;
  logic [LOG2_DEPTH:0] rd_ptr_nxt;
  logic                do_push;
  logic                do_pop;

  assign fill    = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[LOG2_DEPTH] != rd_ptr[LOG2_DEPTH]) &&
                   (wr_ptr[LOG2_DEPTH-1:0] == rd_ptr[LOG2_DEPTH-1:0]);
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so a push into a full FIFO is still taken.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_nxt = wr_ptr + {{LOG2_DEPTH{1'b0}}, do_push};
    rd_ptr_nxt = rd_ptr + {{LOG2_DEPTH{1'b0}}, do_pop};
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[LOG2_DEPTH-1:0]] <= wdata;
    end
  end

  // Head register: when the next head is the slot being written this cycle,
  // forward wdata since mem is not updated until the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rdata  <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      if (wr_ptr_nxt != rd_ptr_nxt) begin
        if (do_push && (rd_ptr_nxt[LOG2_DEPTH-1:0] == wr_ptr[LOG2_DEPTH-1:0])) begin
          rdata <= wdata;
        end else begin
          rdata <= mem[rd_ptr_nxt[LOG2_DEPTH-1:0]];
        end
      end
    end
  end

endmodule

// File: rtl/zad7988_averager.sv
// zad7988_averager: boxcar-averages every 2^LOG2_N accepted ADC samples and
// queues the truncated means in a small FIFO with a valid/ready output.
//   iClk, iRst            clock, asynchronous active-high reset
//   iEn                   enable; low clears the partial average
//   iData, iDataValid     sample stream from the ADC controller
//   oAvg, oAvgValid       FIFO head and non-empty flag
//   iAvgReady             consumer accepts oAvg
//   oFill                 FIFO occupancy
//   oOverrun, iClrOvr     sticky dropped-result flag and its clear
module zad7988_averager
  import zad7988_pkg::*;
#(
  parameter int LOG2_N     = 4,
  parameter int LOG2_DEPTH = 2
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iEn,
  input  logic [ADC_W-1:0]      iData,
  input  logic                  iDataValid,
  output logic [ADC_W-1:0]      oAvg,
  output logic                  oAvgValid,
  input  logic                  iAvgReady,
  output logic [LOG2_DEPTH:0]   oFill,
  output logic                  oOverrun,
  input  logic                  iClrOvr
);

  localparam int ACC_W = ADC_W + LOG2_N;
  localparam int CNT_W = (LOG2_N > 0) ? LOG2_N : 1;
  // With LOG2_N = 0 this is 0, so every accepted sample is the last one.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_N) - 1);

  if (!params_legal(LOG2_N, LOG2_DEPTH)) begin : g_bad_params
    $error("zad7988_averager: LOG2_N or LOG2_DEPTH out of range");
  end

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last;
  logic             push;
  logic             pop;
  logic             drop;
  logic             fifo_empty;
  logic             fifo_full;
  logic [ADC_W-1:0] result;

  assign accept = iEn && iDataValid;
  assign last   = (cnt == CNT_LAST);
  assign sum    = acc + ACC_W'(iData);
  assign result = ADC_W'(sum >> LOG2_N);
  assign push   = accept && last;
  assign pop    = iAvgReady && !fifo_empty;
  assign drop   = push && fifo_full && !pop;

  // Accumulator and sample counter; disable discards any partial sum.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      acc <= '0;
      cnt <= '0;
    end else if (!iEn) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      if (last) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Sticky overrun; a drop in the same cycle wins over the clear.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oOverrun <= 1'b0;
    end else if (drop) begin
      oOverrun <= 1'b1;
    end else if (iClrOvr) begin
      oOverrun <= 1'b0;
    end
  end

  zsync_fifo #(
    .WIDTH      (ADC_W),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_fifo (
    .clk   (iClk),
    .rst   (iRst),
    .push  (push),
    .wdata (result),
    .pop   (iAvgReady),
    .rdata (oAvg),
    .empty (fifo_empty),
    .full  (fifo_full),
    .fill  (oFill)
  );

  assign oAvgValid = !fifo_empty;

endmodule
